// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 priority encoder with a pending-request register and valid/ack handshake.
// Optional registered "multi" (more codes queued) output enabled by ENCODER_MULTI_EN.
module encoder_8to3_seq (
  input  logic clk,
  input  logic rst,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic D5,
  input  logic D6,
  input  logic D7,
  input  logic ack,
  output logic A0,
  output logic A1,
  output logic A2,
  output logic valid
`ifdef ENCODER_MULTI_EN
  ,
  output logic multi
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic [7:0] req;
  logic [7:0] grant_mask;
  logic [2:0] grant_idx;
  logic       grant;
  logic       has_pend;

  assign req      = {D7, D6, D5, D4, D3, D2, D1, D0};
  assign has_pend = |pending_q;

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    grant_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending_q[i]) grant_idx = 3'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    grant      = 1'b0;
    grant_mask = 8'd0;
    case (state_q)
      IDLE: if (has_pend) grant = 1'b1;
      HOLD: begin
        if (ack) begin
          if (has_pend) grant = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d    = HOLD;
      code_d     = grant_idx;
      grant_mask = 8'b1 << grant_idx;
    end
    // A request line high on its own grant edge re-arms the bit.
    pending_d = (pending_q & ~grant_mask) | req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'd0;
      code_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
    end
  end

  assign A0    = code_q[2];
  assign A1    = code_q[1];
  assign A2    = code_q[0];
  assign valid = (state_q == HOLD);

`ifdef ENCODER_MULTI_EN
  logic multi_q, multi_d;

  assign multi_d = (state_d == HOLD) && (|pending_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) multi_q <= 1'b0;
    else     multi_q <= multi_d;
  end

  assign multi = multi_q;
`endif

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Self-checking bench for encoder_8to3_seq: directed scenarios then random traffic,
// compared each cycle against a behavioural request-set model.
module tb_encoder_8to3_seq;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] d;
  logic ack;
  logic A0, A1, A2, valid;
`ifdef ENCODER_MULTI_EN
  logic multi;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit [7:0] m_pend;
  int       m_code;
  bit       m_vld;
  bit       m_multi;

  always #5 clk = ~clk;

  encoder_8to3_seq dut (
    .clk(clk), .rst(rst),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .ack(ack),
    .A0(A0), .A1(A1), .A2(A2), .valid(valid)
`ifdef ENCODER_MULTI_EN
    , .multi(multi)
`endif
  );

  function automatic int highest(input bit [7:0] s);
    int h = -1;
    for (int i = 0; i < 8; i++) if (s[i]) h = i;
    return h;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_code = 0; m_vld = 0; m_multi = 0;
  endtask

  // One rising edge: the handshake frees the slot, the highest queued request
  // takes it, then this cycle's request lines join the queue.
  task automatic model_step(input bit [7:0] din, input bit a);
    if (!m_vld || a) begin
      int h = highest(m_pend);
      if (h >= 0) begin
        m_vld  = 1;
        m_code = h;
        m_pend[h] = 1'b0;
      end else begin
        m_vld = 0;
      end
    end
    m_pend  = m_pend | din;
    m_multi = m_vld && (m_pend != 0);
  endtask

  task automatic check(input string tag);
    logic [2:0] obs_a;
    logic [2:0] exp_a;
    obs_a = {A0, A1, A2};
    exp_a = 3'(m_code);
    n_cmp++;
    assert (valid === m_vld) else begin
      n_err++;
      $error("FAIL %s valid: observed %b expected %b", tag, valid, m_vld);
    end
    n_cmp++;
    assert (obs_a === exp_a) else begin
      n_err++;
      $error("FAIL %s code: observed %b expected %b", tag, obs_a, exp_a);
    end
`ifdef ENCODER_MULTI_EN
    n_cmp++;
    assert (multi === m_multi) else begin
      n_err++;
      $error("FAIL %s multi: observed %b expected %b", tag, multi, m_multi);
    end
`endif
  endtask

  task automatic cycle(input bit [7:0] din, input bit a, input string tag);
    d   = din;
    ack = a;
    @(posedge clk);
    model_step(din, a);
    #1;
    check(tag);
  endtask

  initial begin
    d = 8'h00; ack = 1'b0; rst = 1'b1;
    model_reset();
    #1;
    check("reset_initial");
    // Requests present during reset must not be captured.
    d = 8'hFF;
    @(posedge clk); #1;
    check("reset_hold");
    d = 8'h00;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1, "reset_no_capture");

    // Async reset mid-HOLD with pending 8'hA0
    cycle(8'hA0, 1'b0, "mid_load");
    cycle(8'h00, 1'b0, "mid_grant7");
    cycle(8'h80, 1'b0, "mid_rearm7");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset");
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1, "post_reset_empty");

    // Single D5 with ack held
    cycle(8'h20, 1'b1, "single_load");
    cycle(8'h00, 1'b1, "single_valid");
    cycle(8'h00, 1'b1, "single_drop");

    // Priority / back-to-back: D1, D6, D3
    cycle(8'h4A, 1'b1, "prio_load");
    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b1, "prio_seq");

    // Hold stability with a higher request arriving during HOLD
    cycle(8'h04, 1'b0, "hold_load");
    cycle(8'h00, 1'b0, "hold_grant");
    cycle(8'h80, 1'b0, "hold_d7");
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, "hold_stable");
    cycle(8'h00, 1'b1, "hold_ack");
    cycle(8'h00, 1'b1, "hold_next");
    cycle(8'h00, 1'b1, "hold_idle");

    // Re-arm: D4 held with ack continuously
    for (int i = 0; i < 6; i++) cycle(8'h10, 1'b1, "rearm");
    cycle(8'h00, 1'b1, "rearm_tail");
    cycle(8'h00, 1'b1, "rearm_idle");

    // D0 and D4 together (multi on first grant only)
    cycle(8'h11, 1'b1, "pair_load");
    cycle(8'h00, 1'b1, "pair_g4");
    cycle(8'h00, 1'b1, "pair_g0");
    cycle(8'h00, 1'b1, "pair_idle");

    // All eight at once
    cycle(8'hFF, 1'b1, "all_load");
    for (int i = 0; i < 9; i++) cycle(8'h00, 1'b1, "all_seq");

    // Ack while idle is ignored
    cycle(8'h00, 1'b1, "idle_ack");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit [7:0] r;
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cycle(r, 1'($urandom_range(0, 2) != 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_8to3_seq.md
ENCODER_8TO3_SEQ -- requirements
Module: encoder_8to3_seq

Interface
REQ-001 The block SHALL have these ports: clk  input  1  single clock, all state on rising edge.
REQ-002 The block SHALL have these ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 The block SHALL have these ports: D0..D7  input  1 each  request lines, D7 highest priority.
REQ-004 The block SHALL have these ports: ack  input  1  consumer accepts current code while valid=1.
REQ-005 The block SHALL have these ports: A0, A1, A2  output  1 each  encoded index, A0 = MSB, A2 = LSB, matching the decoder address order so A0..A2 drive decoder A0..A2 directly.
REQ-006 The block SHALL have these ports: valid  output  1  A0..A2 hold a granted code.
REQ-007 The block SHALL have these ports: multi  output  1  only when MULTI_EN is defined (REQ-020).

Function
REQ-008 The block SHALL keep an 8-bit pending register: pending_next = (pending & ~grant_mask) | {D7..D0}, every cycle.
REQ-009 The block SHALL implement a two-state FSM: IDLE (valid=0) and HOLD (valid=1).
REQ-010 In IDLE with pending != 0, the block SHALL grant the highest set pending bit: load its index into A0..A2, clear that bit (grant_mask), go to HOLD.
REQ-011 Latency SHALL be: request high at edge k sets pending; valid=1 with its code after edge k+1 (two edges from input to valid).
REQ-012 In HOLD, A0..A2 and valid SHALL stay stable until ack=1 is sampled.
REQ-013 In HOLD with ack=1 and remaining pending != 0, the block SHALL grant the next highest bit at the same edge and stay in HOLD (back-to-back, no idle cycle).
REQ-014 In HOLD with ack=1 and remaining pending == 0, the block SHALL go to IDLE and deassert valid at that edge; A0..A2 hold last code.
REQ-015 ack while IDLE SHALL be ignored.
REQ-016 A request line high on the same edge its bit is granted SHALL re-set that bit (level-held requests re-arm and are granted again).
REQ-017 A higher-priority request arriving while in HOLD SHALL NOT replace the held code; it wins the next grant.
REQ-018 All eight requests at once SHALL be granted in order 7,6,...,0, one per accepted handshake.

Reset
REQ-019 While rst=1, the block SHALL force state=IDLE, pending=0, A0..A2=000, valid=0, multi=0, immediately (asynchronous), and SHALL resume at the first rising clk edge after rst falls; requests present during reset are not captured.

Configuration
REQ-020 With macro ENCODER_MULTI_EN defined, output multi SHALL be registered and equal 1 when, after the current grant, pending still holds at least one bit (more codes queued); without the macro the multi port and its logic SHALL be absent and all other behaviour identical.

Verification
REQ-021 Reset: rst=1 mid-HOLD with pending=8'hA0 -> A=000, valid=0, pending=0 immediately, no clock needed.
REQ-022 Single: D5 pulsed one cycle, ack=1 -> valid rises two edges after D5 sampled, A0..A2=101, valid falls on the ack edge.
REQ-023 Priority/back-to-back: D1,D6,D3 pulsed together, ack held 1 -> codes 110,011,001 on consecutive cycles, then valid=0.
REQ-024 Hold: D2 pulsed, ack=0 for 5 cycles, D7 pulsed during hold -> A=010 stable 5 cycles; after ack, A=111 next cycle.
REQ-025 Re-arm: D4 held high, ack=1 continuously -> valid stays 1, A=100 every cycle; with ENCODER_MULTI_EN, D0 and D4 together -> multi=1 on first grant (100), multi=0 on grant 000.
